// File: rtl/periodo_defs_pkg.sv
// periodo_defs: shared definitions for the period-measurement exercises.
//   estado_e       : sequencer state encoding (IDLE=0, ARM=1, MEASURE=2, DONE=3)
//   CNT_W_DEF      : default period counter width
//   LOG2_AVG_DEF   : default log2 of periods averaged per measurement
package periodo_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } estado_e;

    localparam int CNT_W_DEF    = 16;
    localparam int LOG2_AVG_DEF = 2;

endpackage

// File: rtl/sincronizador_flanco.sv
// sincronizador_flanco: 2-FF synchronizer plus one delay register, giving a
// one-cycle rising-edge strobe on an asynchronous input.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_async : asynchronous input
//   o_rise  : one-cycle pulse per synchronized rising edge
module sincronizador_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    // [0],[1] are the synchronizer, [2] is the delayed copy for edge detect
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], i_async};
        end
    end

    assign o_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/medidor_periodo_ctrl.sv
// medidor_periodo_ctrl: measures the period of an asynchronous signal in clk
// cycles, averaging 2^LOG2_AVG consecutive periods, with start/done handshake
// and timeout when no edge arrives within 2^CNT_W-1 cycles.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_start     : request a measurement (honoured only in IDLE)
//   i_signal    : asynchronous signal under measurement
//   o_busy      : high while arming or measuring
//   o_done      : one-cycle completion pulse
//   o_timeout   : measurement aborted; held until next accepted i_start
//   o_periodo   : averaged period, held between measurements
module medidor_periodo_ctrl
    import periodo_defs::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOG2_AVG = LOG2_AVG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_signal,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_periodo
);

    localparam int ACC_W = CNT_W + LOG2_AVG;
    localparam int N_W   = LOG2_AVG + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // sample count already held when the final sample arrives
    localparam logic [N_W-1:0]   N_LAST  = N_W'((1 << LOG2_AVG) - 1);

    estado_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]   n_q, n_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] per_q, per_d;

    logic             rise;
    logic [ACC_W-1:0] sum;

    sincronizador_flanco u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(i_signal),
        .o_rise (rise)
    );

    // accumulator including the sample being taken this cycle
    assign sum = acc_q + ACC_W'(cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            tout_q  <= 1'b0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            tout_q  <= tout_d;
            per_q   <= per_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        n_d     = n_q;
        tout_d  = tout_q;
        per_d   = per_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = ARM;
                    cnt_d   = '0;
                    acc_d   = '0;
                    n_d     = '0;
                    tout_d  = 1'b0;
                end
            end
            ARM: begin
                // cnt doubles as timeout timer until the first edge
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DONE;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEASURE: begin
                // an edge on the limit cycle is still a valid sample
                if (rise) begin
                    acc_d = sum;
                    cnt_d = CNT_W'(1);
                    n_d   = n_q + N_W'(1);
                    if (n_q == N_LAST) begin
                        state_d = DONE;
                        per_d   = CNT_W'(sum >> LOG2_AVG);
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DONE;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy    = (state_q == ARM) || (state_q == MEASURE);
    assign o_done    = (state_q == DONE);
    assign o_timeout = tout_q;
    assign o_periodo = per_q;

endmodule
